// File: rtl/alu_suma_serie_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the serial adder alu_suma_serie.
//   estado_t     : FSM state encoding (REPOSO / SUMA / FIN)
//   ANCHO_SLICE  : width of one carry-lookahead slice, in bits
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    SUMA   = 2'd1,
    FIN    = 2'd2
  } estado_t;

  localparam int ANCHO_SLICE = 4;

endpackage

// File: rtl/alu_suma_serie_if.sv
// ---------------------------------------------------------------------------
// alu_suma_serie_if -- operand/result bus of the serial adder.
//   master : drives inicio, a, b, aluflagin (and resta when subtraction is
//            built in); observes listo, valido, aluresult, aluflags, cero.
//   slave  : the adder itself, opposite directions.
// Macro ALU_SUMA_SERIE_RESTA_EN adds the resta signal.
// ---------------------------------------------------------------------------
interface alu_suma_serie_if #(parameter int ANCHO = 16);

  logic             inicio;
  logic [ANCHO-1:0] a;
  logic [ANCHO-1:0] b;
  logic             aluflagin;
`ifdef ALU_SUMA_SERIE_RESTA_EN
  logic             resta;
`endif
  logic             listo;
  logic             valido;
  logic [ANCHO-1:0] aluresult;
  logic             aluflags;
  logic             cero;

`ifdef ALU_SUMA_SERIE_RESTA_EN
  modport master (output inicio, a, b, aluflagin, resta,
                  input  listo, valido, aluresult, aluflags, cero);
  modport slave  (input  inicio, a, b, aluflagin, resta,
                  output listo, valido, aluresult, aluflags, cero);
`else
  modport master (output inicio, a, b, aluflagin,
                  input  listo, valido, aluresult, aluflags, cero);
  modport slave  (input  inicio, a, b, aluflagin,
                  output listo, valido, aluresult, aluflags, cero);
`endif

endinterface

// File: rtl/alu_suma_serie_cla.sv
// ---------------------------------------------------------------------------
// CLA_4bits -- 4-bit carry-lookahead adder slice (purely combinational).
//   a, b       : 4-bit addends
//   aluflagin  : carry-in
//   aluresult  : 4-bit sum
//   aluflags   : carry-out
// ---------------------------------------------------------------------------
module CLA_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       aluflagin,
  output logic [3:0] aluresult,
  output logic       aluflags
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of generate/propagate terms; no ripple chain.
  assign c[0] = aluflagin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign aluresult = p ^ c[3:0];
  assign aluflags  = c[4];

endmodule

// File: rtl/alu_suma_serie.sv
// ---------------------------------------------------------------------------
// alu_suma_serie -- serial adder: a + b + aluflagin, one 4-bit slice per
// clock, LSB slice first, through a single CLA_4bits instance.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_suma_serie_if.slave (inicio, a, b, aluflagin, [resta] in;
//            listo, valido, aluresult, aluflags, cero out)
// Timing: accept edge, N = ANCHO/4 slice edges, then one FIN cycle with
// valido=1, then back to REPOSO (one operation every N+2 cycles).
// Macro ALU_SUMA_SERIE_RESTA_EN: input resta selects a - b (b inverted,
// carry-in forced to 1; aluflags=1 means no borrow).
// ---------------------------------------------------------------------------
module alu_suma_serie
  import alu_pkg::*;
#(
  parameter int ANCHO = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_suma_serie_if.slave  bus
);

  localparam int N     = ANCHO / ANCHO_SLICE;
  localparam int IDX_W = $clog2(N);

  if ((ANCHO % ANCHO_SLICE) != 0 || ANCHO < 8) begin : g_ancho_invalido
    $error("alu_suma_serie: ANCHO must be a multiple of 4 and at least 8");
  end

  estado_t          estado, estado_sig;
  logic [IDX_W-1:0] idx;
  logic [ANCHO-1:0] a_q, b_q, res_q, res_sig;
  logic             carry_q, flag_q, cero_q;
  logic [3:0]       cla_s;
  logic             cla_co;
  logic             ultimo;

  assign ultimo = (idx == IDX_W'(N - 1));

  CLA_4bits u_cla (
    .a         (a_q[idx*ANCHO_SLICE +: ANCHO_SLICE]),
    .b         (b_q[idx*ANCHO_SLICE +: ANCHO_SLICE]),
    .aluflagin (carry_q),
    .aluresult (cla_s),
    .aluflags  (cla_co)
  );

  // Result with the current slice merged in; used both to write the result
  // register and to compute cero on the final slice.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    res_sig = res_q;
    res_sig[idx*ANCHO_SLICE +: ANCHO_SLICE] = cla_s;
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (bus.inicio) estado_sig = SUMA;
      SUMA:    if (ultimo)     estado_sig = FIN;
      FIN:                     estado_sig = REPOSO;
      default:                 estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    bus.listo  = (estado == REPOSO);
    bus.valido = (estado == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      cero_q  <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          // Operands are captured only here, so later input activity is inert.
          if (bus.inicio) begin
            a_q <= bus.a;
            idx <= '0;
`ifdef ALU_SUMA_SERIE_RESTA_EN
            b_q     <= bus.resta ? ~bus.b : bus.b;
            carry_q <= bus.resta | bus.aluflagin;
`else
            b_q     <= bus.b;
            carry_q <= bus.aluflagin;
`endif
          end
        end
        SUMA: begin
          res_q   <= res_sig;
          carry_q <= cla_co;
          // idx parks on the last slice instead of wrapping.
          if (!ultimo) idx <= idx + 1'b1;
          if (ultimo) begin
            flag_q <= cla_co;
            cero_q <= (res_sig == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.aluresult = res_q;
  assign bus.aluflags  = flag_q;
  assign bus.cero      = cero_q;

endmodule

// File: tb/tb_alu_suma_serie.sv
// ---------------------------------------------------------------------------
// tb_alu_suma_serie -- self-checking bench for alu_suma_serie (ANCHO=16).
// A behavioural model (whole-word arithmetic plus a fixed-latency schedule)
// is compared against the DUT on every falling edge; directed scenarios pin
// literal results and timing.
// ---------------------------------------------------------------------------
module tb_alu_suma_serie;

  localparam int ANCHO = 16;
  localparam int N     = ANCHO / 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_suma_serie_if #(.ANCHO(ANCHO)) bus ();

  alu_suma_serie #(.ANCHO(ANCHO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic resta_in;
`ifdef ALU_SUMA_SERIE_RESTA_EN
  assign resta_in = bus.resta;
`else
  assign resta_in = 1'b0;
`endif

  function automatic logic [ANCHO:0] ref_sum(input logic [ANCHO-1:0] x, y,
                                             input logic cin, rs);
    logic [ANCHO-1:0] yy;
    logic             c;
    yy = rs ? ~y : y;
    c  = rs ? 1'b1 : cin;
    return {1'b0, x} + {1'b0, yy} + {{ANCHO{1'b0}}, c};
  endfunction

  // m_t: edges since acceptance (-1 = idle). Results appear after edge N.
  int               m_t      = -1;
  logic [ANCHO-1:0] m_pend   = '0;
  logic             m_pend_c = 1'b0;
  logic [ANCHO-1:0] m_res    = '0;
  logic             m_flag   = 1'b0;
  logic             m_cero   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t    <= -1;
      m_res  <= '0;
      m_flag <= 1'b0;
      m_cero <= 1'b0;
    end else if (m_t < 0) begin
      if (bus.inicio === 1'b1) begin
        {m_pend_c, m_pend} <= ref_sum(bus.a, bus.b, bus.aluflagin, resta_in);
        m_t <= 0;
      end
    end else if (m_t == N - 1) begin
      m_t    <= N;
      m_res  <= m_pend;
      m_flag <= m_pend_c;
      m_cero <= (m_pend == '0);
    end else if (m_t == N) begin
      m_t <= -1;
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    check("listo", bus.listo, m_t < 0);
    check("valido", bus.valido, m_t == N);
    if (m_t < 0 || m_t == N) begin
      check("aluresult", bus.aluresult, m_res);
      check("aluflags", bus.aluflags, m_flag);
      check("cero", bus.cero, m_cero);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_resta(input logic rs);
`ifdef ALU_SUMA_SERIE_RESTA_EN
    bus.resta = rs;
`endif
  endtask

  task automatic wait_listo(input string tag);
    int n = 0;
    while (bus.listo !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, " listo timeout"}, 0, 1);
  endtask

  task automatic run_op(input logic [ANCHO-1:0] x, y, input logic cin, rs,
                        input logic [ANCHO-1:0] er, input logic ef, ec,
                        input string tag);
    int edges;
    wait_listo(tag);
    bus.a = x; bus.b = y; bus.aluflagin = cin; set_resta(rs);
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    edges = 1;
    while (bus.valido !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, edges, N + 1);
    check({tag, " aluresult"}, bus.aluresult, er);
    check({tag, " aluflags"}, bus.aluflags, ef);
    check({tag, " cero"}, bus.cero, ec);
    @(negedge clk);
    check({tag, " listo back"}, bus.listo, 1'b1);
    check({tag, " valido one cycle"}, bus.valido, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, gap, pulses;
    logic [ANCHO-1:0] seen;
    rst_n = 1'b0;
    bus.inicio = 1'b0; bus.a = '0; bus.b = '0; bus.aluflagin = 1'b0;
    set_resta(1'b0);
    repeat (2) @(negedge clk);
    check("reset listo", bus.listo, 1'b1);
    check("reset valido", bus.valido, 1'b0);
    check("reset aluresult", bus.aluresult, 16'h0000);
    check("reset cero", bus.cero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "s1");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "s2");

    // s3: inicio held high; second acceptance only once listo returns.
    wait_listo("s3");
    bus.a = 16'h1234; bus.b = 16'h4321; bus.aluflagin = 1'b1; bus.inicio = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.valido !== 1'b1 && n < 20);
    check("s3 latency", n, N + 1);
    check("s3 aluresult", bus.aluresult, 16'h5556);
    check("s3 aluflags", bus.aluflags, 1'b0);
    gap = 0;
    do begin @(negedge clk); gap++; end while (bus.valido !== 1'b1 && gap < 20);
    check("s3 gap", gap, N + 2);
    check("s3 second aluresult", bus.aluresult, 16'h5556);
    bus.inicio = 1'b0;

    // s4: operand changes and inicio during SUMA are ignored.
    wait_listo("s4");
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.aluflagin = 1'b0; bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0; bus.a = 16'h1357; bus.b = 16'h2468;
    @(negedge clk);
    bus.inicio = 1'b1; bus.a = ANCHO'($urandom); bus.b = ANCHO'($urandom);
    @(negedge clk);
    bus.inicio = 1'b0;
    pulses = 0; seen = '0;
    repeat (12) begin
      @(negedge clk);
      if (bus.valido === 1'b1) begin pulses++; seen = bus.aluresult; end
    end
    check("s4 pulses", pulses, 1);
    check("s4 aluresult", seen, 16'hFFFF);

    // s5: reset during the 2nd SUMA cycle aborts the operation.
    wait_listo("s5");
    bus.a = 16'h1234; bus.b = 16'h1111; bus.aluflagin = 1'b0; bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s5 listo", bus.listo, 1'b1);
    check("s5 valido", bus.valido, 1'b0);
    check("s5 aluresult", bus.aluresult, 16'h0000);
    check("s5 aluflags", bus.aluflags, 1'b0);
    check("s5 cero", bus.cero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.valido === 1'b1) pulses++;
    end
    check("s5 no valido", pulses, 0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "s5 after");

`ifdef ALU_SUMA_SERIE_RESTA_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "s6");
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "s6b");
`endif

    // Random traffic: every cycle gets fresh inputs; the model checks all.
    repeat (600) begin
      @(negedge clk);
      bus.a         = ANCHO'($urandom);
      bus.b         = ($urandom_range(0, 7) == 0) ? ~bus.a : ANCHO'($urandom);
      bus.aluflagin = 1'($urandom);
      bus.inicio    = ($urandom_range(0, 3) != 0);
      set_resta(1'($urandom));
    end
    bus.inicio = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_suma_serie.md
ALU_SUMA_SERIE -- requirements
Module: alu_suma_serie

Interface
REQ-001 The block SHALL have parameter ANCHO, default 16, which is the operand/result width in bits and must be a multiple of 4 and at least 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port inicio, input, 1 bit: start request, sampled only while listo=1.
REQ-005 The block SHALL have ports a and b, input, ANCHO bits each: the operands, latched on the accepted start edge.
REQ-006 The block SHALL have port aluflagin, input, 1 bit: carry-in, latched with the operands.
REQ-007 The block SHALL have port listo, output, 1 bit: idle, meaning a start request can be accepted.
REQ-008 The block SHALL have port valido, output, 1 bit: a one-cycle pulse signalling that the result is complete.
REQ-009 The block SHALL have port aluresult, output, ANCHO bits: the registered sum.
REQ-010 The block SHALL have port aluflags, output, 1 bit: the registered carry-out of the MSB slice.
REQ-011 The block SHALL have port cero, output, 1 bit: set when aluresult is all zeros.

Function
REQ-012 The block SHALL add a, b and aluflagin serially, processing one 4-bit slice per clock, LSB slice first, through one 4-bit carry-lookahead slice.
REQ-013 The FSM SHALL have three states: REPOSO, SUMA and FIN.
- REPOSO -> SUMA when inicio=1.
- SUMA -> FIN after N=ANCHO/4 slice cycles.
- FIN -> REPOSO unconditionally.
REQ-014 In REPOSO, the block SHALL drive listo=1.
- An edge with inicio=1 latches a, b and aluflagin, clears the slice index to 0, and loads the carry register with aluflagin.
REQ-015 In SUMA, each edge SHALL do the following:
- Write slice[idx] of the result from the CLA output, using the carry register as the CLA carry-in.
- Update the carry register with the CLA carry-out.
- Increment idx.
REQ-016 After the edge that writes slice N-1, the block SHALL enter FIN.
- In FIN, valido=1 for exactly one cycle.
- aluresult, aluflags and cero are final and valid in that cycle.
REQ-017 Latency SHALL be fixed: valido is high in the cycle N+1 edges after the accepting edge, and listo returns to 1 one cycle later.
REQ-018 Throughput SHALL be one operation per N+2 cycles.
REQ-019 The index counter SHALL be $clog2(N) bits wide and SHALL NOT wrap inside SUMA; it is reloaded only on acceptance.
REQ-020 inicio while listo=0 SHALL be ignored, and the latched operands SHALL NOT change during SUMA or FIN.
REQ-021 aluresult, aluflags and cero SHALL hold their last values in REPOSO until the next accepted start.
REQ-022 The carry-out of slice N-1 SHALL be aluflags.
- cero is computed from the complete result and is registered together with valido.
REQ-023 Input changes on a and b outside the accepting edge SHALL have no effect on the outputs.

Reset
REQ-024 rst_n=0 SHALL asynchronously force the following:
- state=REPOSO, listo=1, valido=0.
- aluresult=0, aluflags=0, cero=0.
- idx=0, carry register=0, operand registers=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no valido pulse.
- The first edge after release is treated as REPOSO.

Configuration
REQ-026 When macro ALU_SUMA_SERIE_RESTA_EN is defined, the block SHALL add an input resta (1 bit), latched with the operands.
- resta=1 inverts b on latch and forces the latched carry-in to 1, ignoring aluflagin.
- The result is a-b in two's complement, and aluflags=1 means no borrow.
REQ-027 When ALU_SUMA_SERIE_RESTA_EN is undefined, the resta port SHALL NOT exist and the block SHALL perform only a+b+aluflagin.

Structure
REQ-028 The shared package alu_pkg SHALL hold the following; no other package content is required:
- The FSM state typedef (REPOSO/SUMA/FIN).
- The constant ANCHO_SLICE=4.
REQ-029 The block SHALL instantiate the existing 4-bit carry-lookahead sub-module CLA_4bits (ports a, b, aluflagin, aluresult, aluflags) exactly once as the slice datapath.

Verification
REQ-030 The bench SHALL cover the following directed scenarios with ANCHO=16:
- a=0x00FF, b=0x0001, aluflagin=0, inicio pulsed -> valido high on the 5th edge after acceptance; aluresult=0x0100, aluflags=0, cero=0.
- a=0xFFFF, b=0x0001, aluflagin=0 -> aluresult=0x0000, aluflags=1, cero=1.
- a=0x1234, b=0x4321, aluflagin=1 -> aluresult=0x5556, aluflags=0; inicio held high throughout causes a second acceptance only after listo returns to 1.
- Start 0xAAAA+0x5555, change a/b and pulse inicio during SUMA -> result still 0xFFFF, exactly one valido.
- rst_n low during the 2nd SUMA cycle -> no valido; outputs are 0; listo=1; a new operation then completes correctly.
- With ALU_SUMA_SERIE_RESTA_EN, resta=1, a=0x0005, b=0x0007 -> aluresult=0xFFFE, aluflags=0.
